// File: rtl/bin_ascii_pkg.sv
// Shared types and constants for the binary-to-ASCII sequencer.
// Sizes the double-dabble vector and names the sequencer states.
package bin_ascii_pkg;

   typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam int         CONV_STEPS = 8;
   localparam int         BIN_W      = 8;
   localparam int         BCD_W      = 12;
   localparam int         SH_W       = BIN_W + BCD_W;

endpackage

// File: rtl/bin_ascii_dd_step.sv
// One double-dabble iteration on the {bcd,bin} vector: add 3 to every BCD
// nibble that is 5 or more, then shift the whole vector left by one.
module bin_ascii_dd_step
   import bin_ascii_pkg::*;
(
   input  logic [SH_W-1:0] sh_in,
   output logic [SH_W-1:0] sh_out
);

   logic [SH_W-1:0] adj;

   always_comb begin
      adj = sh_in;
      for (int d = 0; d < BCD_W / 4; d++) begin
         if (sh_in[BIN_W + 4*d +: 4] >= 4'd5)
            adj[BIN_W + 4*d +: 4] = sh_in[BIN_W + 4*d +: 4] + 4'd3;
      end
      sh_out = {adj[SH_W-2:0], 1'b0};
   end

endmodule

// File: rtl/bin_ascii_seq_ctrl.sv
// Converts one 8-bit value to BCD with a shared serial double-dabble step and
// streams the digits as ASCII, most significant first, over valid/ready.
module bin_ascii_seq_ctrl
   import bin_ascii_pkg::*;
#(
   parameter bit         SUPPRESS_ZEROS = 1'b1,
   parameter bit         SEND_TERM      = 1'b1,
   parameter logic [7:0] TERM_CHAR      = 8'h0D
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_char,
   output logic       out_last,
   output logic       busy
);

   state_t          state, state_nxt;
   logic [SH_W-1:0] sh, sh_nxt, sh_step;
   logic [2:0]      step, step_nxt;
   logic [1:0]      emit_idx, emit_idx_nxt;
   logic            out_valid_nxt, out_last_nxt, in_ready_nxt;
   logic [7:0]      out_char_nxt;

   logic [3:0]      dig_h, dig_t, dig_u;
   logic [7:0]      char_list [4];
   logic [2:0]      char_cnt;
   logic [1:0]      last_idx;

   bin_ascii_dd_step u_step (
      .sh_in  (sh),
      .sh_out (sh_step)
   );

   assign dig_h = sh[BIN_W + 8 +: 4];
   assign dig_t = sh[BIN_W + 4 +: 4];
   assign dig_u = sh[BIN_W     +: 4];
   assign busy  = (state != IDLE);

   // sh is frozen throughout EMIT, so this list is effectively built once on entry.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      char_list = '{default: 8'h00};
      char_cnt  = 3'd0;
      if (dig_h != 4'd0 || !SUPPRESS_ZEROS) begin
         char_list[char_cnt[1:0]] = ASCII_ZERO + {4'h0, dig_h};
         char_cnt                 = char_cnt + 3'd1;
      end
      if (dig_h != 4'd0 || dig_t != 4'd0 || !SUPPRESS_ZEROS) begin
         char_list[char_cnt[1:0]] = ASCII_ZERO + {4'h0, dig_t};
         char_cnt                 = char_cnt + 3'd1;
      end
      char_list[char_cnt[1:0]] = ASCII_ZERO + {4'h0, dig_u};
      char_cnt                 = char_cnt + 3'd1;
      if (SEND_TERM) begin
         char_list[char_cnt[1:0]] = TERM_CHAR;
         char_cnt                 = char_cnt + 3'd1;
      end
      last_idx = 2'(char_cnt - 3'd1);
   end

   always_comb begin
      state_nxt     = state;
      sh_nxt        = sh;
      step_nxt      = step;
      emit_idx_nxt  = emit_idx;
      out_valid_nxt = out_valid;
      out_char_nxt  = out_char;
      out_last_nxt  = out_last;
      unique case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               sh_nxt    = {{BCD_W{1'b0}}, in_data};
               step_nxt  = 3'd0;
               state_nxt = CONV;
            end
         end
         CONV: begin
            sh_nxt   = sh_step;
            step_nxt = step + 3'd1;
            if (step == 3'(CONV_STEPS - 1))
               state_nxt = EMIT;
         end
         EMIT: begin
            // First EMIT cycle only loads the output stage; transfers follow back to back.
            if (!out_valid) begin
               out_valid_nxt = 1'b1;
               out_char_nxt  = char_list[0];
               out_last_nxt  = (last_idx == 2'd0);
               emit_idx_nxt  = 2'd0;
            end else if (out_ready) begin
               if (out_last) begin
                  out_valid_nxt = 1'b0;
                  out_char_nxt  = 8'h00;
                  out_last_nxt  = 1'b0;
                  emit_idx_nxt  = 2'd0;
                  state_nxt     = IDLE;
               end else begin
                  emit_idx_nxt = emit_idx + 2'd1;
                  out_char_nxt = char_list[emit_idx + 2'd1];
                  out_last_nxt = ((emit_idx + 2'd1) == last_idx);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Registered from the next state so in_ready is low during reset and never
      // depends combinationally on in_valid or out_ready.
      in_ready_nxt = (state_nxt == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sh        <= '0;
         step      <= 3'd0;
         emit_idx  <= 2'd0;
         out_valid <= 1'b0;
         out_char  <= 8'h00;
         out_last  <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state     <= state_nxt;
         sh        <= sh_nxt;
         step      <= step_nxt;
         emit_idx  <= emit_idx_nxt;
         out_valid <= out_valid_nxt;
         out_char  <= out_char_nxt;
         out_last  <= out_last_nxt;
         in_ready  <= in_ready_nxt;
      end
   end

endmodule

// File: tb/tb_bin_ascii_seq_ctrl.sv
// Directed and sweep bench for bin_ascii_seq_ctrl: default instance plus one with
// leading zeros kept and no terminator; sel picks which instance is exercised.
module tb_bin_ascii_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       out_ready = 1'b0;
   logic       sel = 1'b0;

   logic       d_in_ready, d_out_valid, d_out_last, d_busy;
   logic [7:0] d_out_char;
   logic       z_in_ready, z_out_valid, z_out_last, z_busy;
   logic [7:0] z_out_char;

   logic       in_ready, out_valid, out_last, busy;
   logic [7:0] out_char;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_chars [4];
   int         exp_n = 0;

   always #5 clk = ~clk;

   bin_ascii_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid & ~sel),
      .in_ready  (d_in_ready),
      .in_data   (in_data),
      .out_valid (d_out_valid),
      .out_ready (out_ready),
      .out_char  (d_out_char),
      .out_last  (d_out_last),
      .busy      (d_busy)
   );

   bin_ascii_seq_ctrl #(
      .SUPPRESS_ZEROS (1'b0),
      .SEND_TERM      (1'b0),
      .TERM_CHAR      (8'h0D)
   ) dut_nz (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid & sel),
      .in_ready  (z_in_ready),
      .in_data   (in_data),
      .out_valid (z_out_valid),
      .out_ready (out_ready),
      .out_char  (z_out_char),
      .out_last  (z_out_last),
      .busy      (z_busy)
   );

   assign in_ready  = sel ? z_in_ready  : d_in_ready;
   assign out_valid = sel ? z_out_valid : d_out_valid;
   assign out_char  = sel ? z_out_char  : d_out_char;
   assign out_last  = sel ? z_out_last  : d_out_last;
   assign busy      = sel ? z_busy      : d_busy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: hundreds/tens/units by division, then leading-zero and terminator rules.
   task automatic set_model(input int v, input bit sz, input bit st);
      int c = v / 100;
      int d = (v / 10) % 10;
      int u = v % 10;
      exp_n = 0;
      if (c != 0 || !sz) begin exp_chars[exp_n] = 8'(8'h30 + c); exp_n++; end
      if (c != 0 || d != 0 || !sz) begin exp_chars[exp_n] = 8'(8'h30 + d); exp_n++; end
      exp_chars[exp_n] = 8'(8'h30 + u);
      exp_n++;
      if (st) begin exp_chars[exp_n] = 8'h0D; exp_n++; end
   endtask

   task automatic drive_in(input logic [7:0] v, input bit hold);
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      check("in_ready_wait", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
   endtask

   // mode 0: ready always high, 1: ready toggles 1010.., 2: random ready.
   task automatic collect(input string tag, input int mode, input bit chk_lat);
      int         cyc = 0;
      int         k = 0;
      int         guard = 0;
      bit         stalled = 1'b0;
      logic [7:0] pc = 8'h00;
      logic       pl = 1'b0;
      while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
      check({tag, "_valid"}, out_valid, 1'b1);
      if (chk_lat) check({tag, "_latency"}, cyc, 9);
      while (k < exp_n && guard < 200) begin
         @(negedge clk);
         guard++;
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (guard % 2 == 1);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (stalled) begin
            check({tag, "_stall_valid"}, out_valid, 1'b1);
            check({tag, "_stall_char"}, out_char, pc);
            check({tag, "_stall_last"}, out_last, pl);
         end
         if (mode == 0) check({tag, "_stream"}, out_valid, 1'b1);
         if (out_valid && out_ready) begin
            check($sformatf("%s_char%0d", tag, k), out_char, exp_chars[k]);
            check($sformatf("%s_last%0d", tag, k), out_last, (k == exp_n - 1));
            k++;
            stalled = 1'b0;
         end else if (out_valid) begin
            stalled = 1'b1;
            pc      = out_char;
            pl      = out_last;
         end
      end
      check({tag, "_count"}, k, exp_n);
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_done_valid"}, out_valid, 1'b0);
      check({tag, "_done_busy"}, busy, 1'b0);
      check({tag, "_done_ready"}, in_ready, 1'b1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      #1;
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_char", out_char, 8'h00);
      check("rst_out_last", out_last, 1'b0);
      check("rst_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", in_ready, 1'b1);

      // 0 -> "0\r", first out_valid 9 edges after accept
      exp_chars = '{8'h30, 8'h0D, 8'h00, 8'h00}; exp_n = 2;
      drive_in(8'd0, 1'b0);
      collect("v0", 0, 1'b1);

      // 255 at full rate
      exp_chars = '{8'h32, 8'h35, 8'h35, 8'h0D}; exp_n = 4;
      drive_in(8'd255, 1'b0);
      collect("v255", 0, 1'b1);

      // leading zeros kept, no terminator
      sel = 1'b1;
      exp_chars = '{8'h30, 8'h30, 8'h37, 8'h00}; exp_n = 3;
      drive_in(8'd7, 1'b0);
      collect("nz7", 0, 1'b1);
      @(negedge clk);
      sel = 1'b0;

      // 105 with toggling ready
      exp_chars = '{8'h31, 8'h30, 8'h35, 8'h0D}; exp_n = 4;
      drive_in(8'd105, 1'b0);
      collect("v105", 1, 1'b1);

      // in_valid held while busy; changed data must not be taken until in_ready returns
      exp_chars = '{8'h34, 8'h32, 8'h0D, 8'h00}; exp_n = 3;
      drive_in(8'd42, 1'b1);
      in_data = 8'd99;
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_busy", busy, 1'b1);
      collect("h42", 0, 1'b1);
      @(posedge clk); #1;
      check("h99_accepted", busy, 1'b1);
      in_valid = 1'b0;
      exp_chars = '{8'h39, 8'h39, 8'h0D, 8'h00}; exp_n = 3;
      collect("h99", 0, 1'b0);

      // reset during the second character of 200
      drive_in(8'd200, 1'b0);
      t = 0;
      while (!out_valid && t < 40) begin @(posedge clk); #1; t++; end
      check("r200_first_char", out_char, 8'h32);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("r200_second_char", out_char, 8'h30);
      check("r200_second_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_in_ready", in_ready, 1'b0);
      check("abort_out_char", out_char, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_idle_ready", in_ready, 1'b1);
      check("abort_idle_valid", out_valid, 1'b0);
      exp_chars = '{8'h31, 8'h33, 8'h0D, 8'h00}; exp_n = 3;
      drive_in(8'd13, 1'b0);
      collect("v13", 0, 1'b1);

      // full sweep against the division model, random backpressure
      for (int v = 0; v < 256; v++) begin
         set_model(v, 1'b1, 1'b1);
         drive_in(8'(v), 1'b0);
         collect($sformatf("sw%0d", v), 2, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
